// File: rtl/param_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : param_deserializer_pkg
// Description : Shared types and constants for the serial-to-parallel
//               deserializer: FSM state encoding, legal frame-width range
//               and bit-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package param_deserializer_pkg;

   // Legal frame data width range
   localparam int DATA_WIDTH_MIN = 5;
   localparam int DATA_WIDTH_MAX = 9;

   // Width of the accepted-bit counter (holds 0..DATA_WIDTH_MAX)
   localparam int CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FULL  = 2'd2
   } deser_state_t;

endpackage : param_deserializer_pkg
`default_nettype wire

// File: rtl/deser_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : deser_bit_cnt
// Description : Counts data bits accepted in the current frame. Saturates at
//               DATA_WIDTH; a synchronous clear has priority over increment.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               i_clr  - clear the count at the next edge
//               i_inc  - increment the count (saturating)
//               o_cnt  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module deser_bit_cnt
   import param_deserializer_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clr,
   input  logic                 i_inc,
   output logic [CNT_WIDTH-1:0] o_cnt
);

   localparam logic [CNT_WIDTH-1:0] c_MAX = CNT_WIDTH'(DATA_WIDTH);

   logic [CNT_WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt < c_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule : deser_bit_cnt
`default_nettype wire

// File: rtl/param_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : param_deserializer
// Description : Serial-to-parallel frame deserializer. Accepts one bit per
//               strobe while deser_en is high, publishes the completed word
//               on P_DAta with a one-cycle data_valid pulse, and flags a
//               sticky overrun for strobes arriving once the word is full.
// Ports       : CLK           - clock, rising edge
//               RST           - asynchronous active-low reset
//               sampled_bit   - serial data bit
//               deser_New_bit - one-cycle strobe, sampled_bit valid
//               deser_en      - frame data phase active
//               clr_ovr       - clear sticky overrun
//               P_DAta        - last completed word (registered)
//               data_valid    - one-cycle pulse when P_DAta updates
//               bit_cnt       - bits accepted in the current frame
//               overrun       - sticky overrun flag
// Revision    : 1.0 - initial release
// ============================================================================
module param_deserializer
   import param_deserializer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LSB_FIRST  = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  sampled_bit,
   input  logic                  deser_New_bit,
   input  logic                  deser_en,
   input  logic                  clr_ovr,
   output logic [DATA_WIDTH-1:0] P_DAta,
   output logic                  data_valid,
   output logic [CNT_WIDTH-1:0]  bit_cnt,
   output logic                  overrun
);

   generate
      if ((DATA_WIDTH < DATA_WIDTH_MIN) || (DATA_WIDTH > DATA_WIDTH_MAX)) begin : g_width_bad
         $error("param_deserializer: DATA_WIDTH %0d outside legal range %0d..%0d",
                DATA_WIDTH, DATA_WIDTH_MIN, DATA_WIDTH_MAX);
      end
   endgenerate

   // Count value at which the next accepted bit completes the word
   localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

   deser_state_t            r_state;
   logic [DATA_WIDTH-1:0]   r_sr;
   logic [DATA_WIDTH-1:0]   r_data;
   logic                    r_valid;
   logic                    r_ovr;

   logic [DATA_WIDTH-1:0]   w_sr_next;
   logic [CNT_WIDTH-1:0]    w_cnt;
   logic                    w_accept;
   logic                    w_last;

   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign w_sr_next = {sampled_bit, r_sr[DATA_WIDTH-1:1]};
      end else begin : g_msb_first
         assign w_sr_next = {r_sr[DATA_WIDTH-2:0], sampled_bit};
      end
   endgenerate

   // A strobe is taken in IDLE too, so the first bit may coincide with
   // the rising edge of deser_en.
   assign w_accept = deser_en && deser_New_bit && (r_state != ST_FULL);
   assign w_last   = (w_cnt == c_LAST);

   deser_bit_cnt #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_bit_cnt (
      .clk   (CLK),
      .rst_n (RST),
      .i_clr (!deser_en),
      .i_inc (w_accept),
      .o_cnt (w_cnt)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
         r_sr    <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_valid <= 1'b0;

         // Clear first so a same-cycle set below wins
         if (clr_ovr) begin
            r_ovr <= 1'b0;
         end

         if (!deser_en) begin
            // Abandon any partial word without publishing it
            r_state <= ST_IDLE;
            r_sr    <= '0;
         end else begin
            case (r_state)
               ST_IDLE, ST_SHIFT: begin
                  r_state <= ST_SHIFT;
                  if (deser_New_bit) begin
                     r_sr <= w_sr_next;
                     if (w_last) begin
                        r_data  <= w_sr_next;
                        r_valid <= 1'b1;
                        r_state <= ST_FULL;
                     end
                  end
               end
               ST_FULL: begin
                  if (deser_New_bit) begin
                     r_ovr <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign P_DAta     = r_data;
   assign data_valid = r_valid;
   assign bit_cnt    = w_cnt;
   assign overrun    = r_ovr;

endmodule : param_deserializer
`default_nettype wire

// File: tb/tb_param_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_deserializer
// Description : Directed self-checking bench for param_deserializer. Two
//               8-bit instances (LSB-first and MSB-first) share one stimulus
//               stream; a 5-bit LSB-first instance has its own.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_deserializer;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RST;

   // Stimulus shared by the two 8-bit instances
   logic sb, nb, en, clr;
   // Stimulus for the 5-bit instance
   logic sb5, nb5, en5, clr5;

   logic [7:0] pd_l, pd_m;
   logic       dv_l, dv_m, ov_l, ov_m;
   logic [3:0] bc_l, bc_m;

   logic [4:0] pd_5;
   logic       dv_5, ov_5;
   logic [3:0] bc_5;

   int n_checks = 0;
   int n_errors = 0;

   param_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1)) u_dut_l (
      .CLK(CLK), .RST(RST), .sampled_bit(sb), .deser_New_bit(nb),
      .deser_en(en), .clr_ovr(clr), .P_DAta(pd_l), .data_valid(dv_l),
      .bit_cnt(bc_l), .overrun(ov_l));

   param_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(0)) u_dut_m (
      .CLK(CLK), .RST(RST), .sampled_bit(sb), .deser_New_bit(nb),
      .deser_en(en), .clr_ovr(clr), .P_DAta(pd_m), .data_valid(dv_m),
      .bit_cnt(bc_m), .overrun(ov_m));

   param_deserializer #(.DATA_WIDTH(5), .LSB_FIRST(1)) u_dut_5 (
      .CLK(CLK), .RST(RST), .sampled_bit(sb5), .deser_New_bit(nb5),
      .deser_en(en5), .clr_ovr(clr5), .P_DAta(pd_5), .data_valid(dv_5),
      .bit_cnt(bc_5), .overrun(ov_5));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send8(input logic b);
      en = 1'b1; nb = 1'b1; sb = b;
      tick();
      nb = 1'b0;
   endtask

   task automatic send5(input logic b);
      en5 = 1'b1; nb5 = 1'b1; sb5 = b;
      tick();
      nb5 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic b8 [8];
      logic b5 [5];
      b8 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      b5 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      RST = 1'b1;
      sb = 1'b0; nb = 1'b0; en = 1'b0; clr = 1'b0;
      sb5 = 1'b0; nb5 = 1'b0; en5 = 1'b0; clr5 = 1'b0;
      #1 RST = 1'b0;
      #2;
      // Reset values, before any clock edge
      check("rst_pdata", 32'(pd_l), 32'h0);
      check("rst_valid", 32'(dv_l), 32'h0);
      check("rst_bitcnt", 32'(bc_l), 32'h0);
      check("rst_ovr", 32'(ov_l), 32'h0);

      tick(); tick();
      RST = 1'b1;
      tick();

      // Full 8-bit frame; first strobe coincides with deser_en rising
      for (int i = 0; i < 8; i++) begin
         send8(b8[i]);
         if (i < 7) begin
            check($sformatf("frame_bitcnt_%0d", i), 32'(bc_l), 32'(i + 1));
            check($sformatf("frame_novalid_%0d", i), 32'(dv_l), 32'h0);
         end
      end
      check("lsb_pdata", 32'(pd_l), 32'h35);
      check("lsb_valid", 32'(dv_l), 32'h1);
      check("lsb_bitcnt", 32'(bc_l), 32'h8);
      check("msb_pdata", 32'(pd_m), 32'hAC);
      check("msb_valid", 32'(dv_m), 32'h1);

      tick();
      check("valid_one_cycle", 32'(dv_l), 32'h0);
      check("pdata_hold", 32'(pd_l), 32'h35);

      // Strobe while full -> overrun, data and count untouched
      send8(1'b1);
      check("ovr_set", 32'(ov_l), 32'h1);
      check("ovr_pdata", 32'(pd_l), 32'h35);
      check("ovr_novalid", 32'(dv_l), 32'h0);
      check("ovr_bitcnt_sat", 32'(bc_l), 32'h8);

      clr = 1'b1;
      send8(1'b0);
      clr = 1'b0;
      check("ovr_set_wins", 32'(ov_l), 32'h1);

      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("ovr_clear", 32'(ov_l), 32'h0);

      en = 1'b0;
      tick();
      check("en_low_bitcnt", 32'(bc_l), 32'h0);

      // Strobe with deser_en low does nothing
      nb = 1'b1; sb = 1'b1;
      tick();
      nb = 1'b0;
      check("strobe_no_en", 32'(bc_l), 32'h0);

      // Partial frame then abort
      for (int i = 0; i < 5; i++) begin
         send8(1'b1);
      end
      check("partial_bitcnt", 32'(bc_l), 32'h5);
      en = 1'b0;
      tick();
      check("abort_bitcnt", 32'(bc_l), 32'h0);
      check("abort_novalid", 32'(dv_l), 32'h0);
      check("abort_pdata_l", 32'(pd_l), 32'h35);
      check("abort_pdata_m", 32'(pd_m), 32'hAC);

      // 5-bit instance
      for (int i = 0; i < 5; i++) begin
         send5(b5[i]);
      end
      check("w5_pdata", 32'(pd_5), 32'h13);
      check("w5_valid", 32'(dv_5), 32'h1);
      check("w5_bitcnt", 32'(bc_5), 32'h5);

      en5 = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         send5(1'b1);
      end
      check("w5_partial_bitcnt", 32'(bc_5), 32'h3);

      // Asynchronous reset between strobes 3 and 4
      RST = 1'b0;
      #2;
      check("arst_pdata", 32'(pd_5), 32'h0);
      check("arst_valid", 32'(dv_5), 32'h0);
      check("arst_bitcnt", 32'(bc_5), 32'h0);
      check("arst_ovr", 32'(ov_5), 32'h0);
      check("arst_pdata8", 32'(pd_l), 32'h0);

      en5 = 1'b0;
      tick();
      RST = 1'b1;
      nb5 = 1'b1; sb5 = 1'b1;
      tick();
      nb5 = 1'b0;
      check("post_rst_wait_bitcnt", 32'(bc_5), 32'h0);
      check("post_rst_wait_pdata", 32'(pd_5), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_param_deserializer
`default_nettype wire
